regbank_wr_arbiter: RTL and testbench



---
 rtl/regbank_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regbank_wr_arbiter.sv | 110 +++++++++++
 tb/tb_regbank_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
// Shared constants and helpers for the register-bank write arbiter.
//   NREQ_DEF / DEPTH_DEF / WIDTH_DEF : default parameter values
//   onehot_to_idx()                  : index of the lowest set bit of a vector
// ---------------------------------------------------------------------------
package regbank_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 8;

  // Converts a one-hot vector (zero-extended to 32 bits) into its bit index.
  // An all-zero vector maps to index 0, which callers treat as "don't care"
  // because they only use the index while the vector is non-zero.
  function automatic int onehot_to_idx(input logic [31:0] onehot);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector.
//   req_vec      in  NREQ : eligible requesters this cycle
//   last         in  IW   : index of the most recent winner
//   grant_onehot out NREQ : one-hot winner (all zero when nobody is eligible)
//   grant_idx    out IW   : binary index of the winner
// ---------------------------------------------------------------------------
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_vec,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IW-1:0]   grant_idx
);

  logic found;
  int   cand;

  // Walk the requesters starting just after the previous winner and wrapping
  // around; the first eligible one wins. Starting at last+1 is what makes the
  // previous winner the lowest priority and gives the rotation its fairness.
  always_comb begin
    grant_onehot = '0;
    found        = 1'b0;
    cand         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req_vec[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  // The binary index is derived from the one-hot grant so both views can
  // never disagree.
  assign grant_idx = IW'(onehot_to_idx(32'(grant_onehot)));

endmodule

// File: rtl/regbank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wr_arbiter
// Shares one bank of DEPTH enabled registers between NREQ write requesters.
// A round-robin arbiter grants at most one write per cycle; the write lands
// on the rising edge and a registered grant pulse reports it one cycle later.
//   sys_clk  in  1          : system clock, rising edge
//   sys_rst  in  1          : asynchronous active-high reset
//   req      in  NREQ       : per-requester write request (held until granted)
//   wr_addr  in  NREQ*AW    : requester i address at [i*AW +: AW]
//   wr_data  in  NREQ*WIDTH : requester i data at [i*WIDTH +: WIDTH]
//   gnt      out NREQ       : one-hot pulse, write completed at previous edge
//   gnt_id   out log2(NREQ) : index of the current grant (valid while gnt!=0)
//   rd_addr  in  AW         : asynchronous read address
//   rd_data  out WIDTH      : bank[rd_addr], no write bypass
//   busy     out 1          : registered, some unmasked request was pending
// ---------------------------------------------------------------------------
module regbank_wr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [IW-1:0]         gnt_id,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy
);

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  win_onehot;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    last;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic [DEPTH-1:0] bank_en;
  logic [WIDTH-1:0] bank [DEPTH];

  // A requester that was just granted is masked for one cycle so it has time
  // to drop req or present new address/data; otherwise a held req would be
  // written twice with stale data.
  assign eligible = req & ~gnt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_vec      (eligible),
    .last         (last),
    .grant_onehot (win_onehot),
    .grant_idx    (win_idx)
  );

  // Only the winner's slices are ever looked at, so garbage on a losing
  // requester's address or data cannot reach the bank.
  always_comb begin
    win_addr = wr_addr[int'(win_idx)*AW +: AW];
    win_data = wr_data[int'(win_idx)*WIDTH +: WIDTH];
  end

  // Decode the winning address into a one-hot register enable; nothing is
  // enabled in a cycle without an eligible requester.
  always_comb begin
    bank_en = '0;
    if (|eligible) bank_en[win_addr] = 1'b1;
  end

  // The register bank: each entry is a plain enabled flip-flop that loads the
  // winner's data when its enable is set.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int e = 0; e < DEPTH; e++) bank[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (bank_en[e]) bank[e] <= win_data;
      end
    end
  end

  // Grant bookkeeping. The pointer resets to the highest index so requester 0
  // is first in line; it only moves when a write actually happens, so idle
  // cycles do not disturb the rotation. gnt_id holds its value while idle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      last   <= IW'(NREQ - 1);
    end else begin
      gnt  <= win_onehot;
      busy <= |eligible;
      if (|eligible) begin
        gnt_id <= win_idx;
        last   <= win_idx;
      end
    end
  end

  // Asynchronous read straight from the bank; a same-cycle write becomes
  // visible only after the edge.
  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
`timescale 1ns/1ps
module tb_regbank_wr_arbiter;
  import regbank_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(NREQ);

  logic                  sys_clk = 1'b0;
  logic                  sys_rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         gnt_id;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  regbank_wr_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #10 sys_clk = ~sys_clk;

  // Behavioural model: bank contents, grant pulse, busy flag, last winner.
  logic [WIDTH-1:0] m_bank [DEPTH];
  logic [NREQ-1:0]  m_gnt    = '0;
  int               m_gnt_id = 0;
  bit               m_busy   = 1'b0;
  int               m_last   = NREQ - 1;
  logic [NREQ-1:0]  m_elig;
  int               m_win;

  // Round-robin rule: first eligible index after the last winner, wrapping.
  function automatic int pickWinner(input logic [NREQ-1:0] e, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      if (e[(lst + k) % NREQ]) return (lst + k) % NREQ;
    end
    return -1;
  endfunction

  assign m_elig = req & ~m_gnt;
  always_comb m_win = pickWinner(m_elig, m_last);

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int e = 0; e < DEPTH; e++) m_bank[e] <= '0;
      m_gnt    <= '0;
      m_gnt_id <= 0;
      m_busy   <= 1'b0;
      m_last   <= NREQ - 1;
    end else begin
      m_busy <= (m_elig != 0);
      if (m_win >= 0) begin
        m_bank[wr_addr[m_win*AW +: AW]] <= wr_data[m_win*WIDTH +: WIDTH];
        m_gnt    <= NREQ'(1) << m_win;
        m_gnt_id <= m_win;
        m_last   <= m_win;
      end else begin
        m_gnt <= '0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge sys_clk) begin
    if (check_en) begin
      checkOutput("gnt", 32'(gnt), 32'(m_gnt));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      if (m_gnt != 0) checkOutput("gnt_id", 32'(gnt_id), 32'(m_gnt_id));
      checkOutput("rd_data", 32'(rd_data), 32'(m_bank[rd_addr]));
    end
  end

  task automatic applyStimulus(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_addr[i*AW +: AW]       = a;
    wr_data[i*WIDTH +: WIDTH] = d;
    req[i]                    = 1'b1;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic resetDut();
    req     = '0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic readCheck(input string name, input int a, input logic [WIDTH-1:0] exp);
    rd_addr = AW'(a);
    #1;
    checkOutput(name, 32'(rd_data), 32'(exp));
  endtask

  int wcount;

  initial begin
    sys_rst = 1'b1;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    tick();
    tick();
    sys_rst  = 1'b0;
    check_en = 1'b1;

    // Test 1: async reset mid-cycle while all request
    for (int i = 0; i < NREQ; i++) applyStimulus(i, AW'(i + 4), WIDTH'(8'h50 + i));
    tick();
    tick();
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    checkOutput("t1_gnt_async", 32'(gnt), 32'h0);
    checkOutput("t1_busy_async", 32'(busy), 32'h0);
    for (int e = 0; e < DEPTH; e++) readCheck("t1_rd_reset", e, 8'h00);
    req = '0;
    tick();
    sys_rst = 1'b0;
    tick();
    tick();
    for (int e = 0; e < DEPTH; e++) readCheck("t1_rd_idle", e, 8'h00);

    // Test 2: single write
    resetDut();
    applyStimulus(2, 3'd3, 8'hA5);
    rd_addr = 3'd3;
    tick();
    req = '0;
    @(negedge sys_clk);
    checkOutput("t2_gnt", 32'(gnt), 32'h4);
    checkOutput("t2_gnt_id", 32'(gnt_id), 32'd2);
    checkOutput("t2_gnt_id_pkg", 32'(onehot_to_idx(32'(gnt))), 32'd2);
    checkOutput("t2_rd", 32'(rd_data), 32'hA5);
    for (int e = 0; e < DEPTH; e++) if (e != 3) readCheck("t2_rd_other", e, 8'h00);

    // Test 3: round robin 0,1,2,3 with everyone requesting
    resetDut();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, AW'(i), WIDTH'(8'h10 + i));
    for (int k = 0; k < NREQ; k++) begin
      tick();
      checkOutput("t3_gnt_id", 32'(gnt_id), 32'(k));
      checkOutput("t3_gnt", 32'(gnt), 32'(1) << k);
    end
    req = '0;
    for (int i = 0; i < NREQ; i++) readCheck("t3_bank", i, WIDTH'(8'h10 + i));

    // Test 4: one continuous requester gets every other cycle
    resetDut();
    applyStimulus(1, 3'd6, 8'h5A);
    wcount = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("t4_gnt1", 32'(gnt[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (gnt[1]) wcount++;
    end
    req = '0;
    checkOutput("t4_writes", 32'(wcount), 32'd3);

    // Test 5: collision on address 5 with pointer at 0
    resetDut();
    applyStimulus(0, 3'd7, 8'h77);
    tick();
    req = '0;
    tick();
    applyStimulus(0, 3'd5, 8'h11);
    applyStimulus(3, 3'd5, 8'h33);
    tick();
    checkOutput("t5_first", 32'(gnt_id), 32'd3);
    readCheck("t5_mid", 5, 8'h33);
    tick();
    req = '0;
    checkOutput("t5_second", 32'(gnt_id), 32'd0);
    readCheck("t5_final", 5, 8'h11);

    // Test 6: reset before the edge drops pending requests
    resetDut();
    applyStimulus(0, 3'd2, 8'hC0);
    applyStimulus(1, 3'd4, 8'hC1);
    #5;
    sys_rst = 1'b1;
    #1;
    checkOutput("t6_gnt_rst", 32'(gnt), 32'h0);
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b0;
    #1;
    checkOutput("t6_gnt_after", 32'(gnt), 32'h0);
    readCheck("t6_nowrite", 2, 8'h00);
    tick();
    checkOutput("t6_regrant", 32'(gnt), 32'h1);
    readCheck("t6_written", 2, 8'hC0);
    req = '0;

    // Random phase, with occasional mid-cycle resets
    resetDut();
    for (int n = 0; n < 3000; n++) begin
      tick();
      sys_rst = 1'b0;
      req     = NREQ'($urandom);
      wr_addr = (NREQ*AW)'({$urandom, $urandom});
      wr_data = (NREQ*WIDTH)'({$urandom, $urandom});
      rd_addr = AW'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #4;
        sys_rst = 1'b1;
      end
    end
    sys_rst = 1'b0;
    req     = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
